// File: rtl/uart_pkg.sv
// Shared types and constants for the word-oriented UART transmit path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int PAR_NONE   = 0;
  localparam int PAR_EVEN   = 1;
  localparam int PAR_ODD    = 2;
  localparam int OVERSAMPLE = 16;

endpackage

// File: rtl/word_fifo.sv
// Synchronous word FIFO with registered level; head word is readable combinationally.
// A push while full is rejected even if a pop happens in the same cycle.
module word_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_pop,
  output logic [DATA_WIDTH-1:0] o_rdata,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [ADDR_WIDTH:0]   o_level
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_level;
  logic                  w_push_ok;
  logic                  w_pop_ok;

  assign o_full    = (r_level == DEPTH);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/uart_word_tx.sv
// Buffered UART word transmitter: each FIFO word goes out as WORD_BYTES back-to-back frames.
// Push-to-start-bit latency is 2 cycles; pushes while full are dropped and flagged by o_overflow.
module uart_word_tx
  import uart_pkg::*;
#(
  parameter int WORD_BYTES      = 4,
  parameter int FIFO_ADDR_WIDTH = 8,
  parameter int STP_BITS_TICKS  = 16,
  parameter int PARITY_MODE     = 0,
  parameter int MSB_FIRST       = 0
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_bd_tick,
  input  logic                      i_wr,
  input  logic [8*WORD_BYTES-1:0]   i_wr_data,
  output logic                      o_tx,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [FIFO_ADDR_WIDTH:0]  o_level,
  output logic                      o_busy,
  output logic                      o_word_done,
  output logic                      o_overflow
);

  localparam int WW   = 8 * WORD_BYTES;
  localparam int MAXT = (STP_BITS_TICKS > OVERSAMPLE) ? STP_BITS_TICKS : OVERSAMPLE;
  localparam int TW   = $clog2(MAXT);
  localparam int BW   = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

  localparam logic [TW-1:0] BIT_END  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP_END = TW'(STP_BITS_TICKS - 1);
  localparam logic [BW-1:0] LAST_BYTE = BW'(WORD_BYTES - 1);

  tx_state_t     r_state, w_state_nxt;
  logic [TW-1:0] r_tick_cnt, w_tick_nxt;
  logic [2:0]    r_bit_idx, w_bit_nxt;
  logic [BW-1:0] r_byte_idx, w_byte_nxt;
  logic [WW-1:0] r_word, w_word_nxt;
  logic          r_word_done, w_done_nxt;
  logic          r_overflow;

  logic          w_pop;
  logic          w_fifo_empty;
  logic          w_fifo_full;
  logic [WW-1:0] w_fifo_rdata;
  logic [BW-1:0] w_sel;
  logic [7:0]    w_byte;
  logic          w_bit_end;
  logic          w_tx;

  word_fifo #(
    .DATA_WIDTH (WW),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (i_wr),
    .i_wdata (i_wr_data),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (o_level)
  );

  // Byte order is resolved at selection time; the captured word itself is never reshuffled.
  assign w_sel     = (MSB_FIRST != 0) ? (LAST_BYTE - r_byte_idx) : r_byte_idx;
  assign w_byte    = r_word[{w_sel, 3'b000} +: 8];
  assign w_bit_end = i_bd_tick && (r_tick_cnt == BIT_END);

  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    w_bit_nxt   = r_bit_idx;
    w_byte_nxt  = r_byte_idx;
    w_word_nxt  = r_word;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;
    w_tx        = 1'b1;

    if (i_bd_tick && (r_state != IDLE)) w_tick_nxt = r_tick_cnt + 1'b1;

    case (r_state)
      IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_word_nxt  = w_fifo_rdata;
          w_byte_nxt  = '0;
          w_tick_nxt  = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        w_tx = 1'b0;
        if (w_bit_end) begin
          w_tick_nxt  = '0;
          w_bit_nxt   = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        w_tx = w_byte[r_bit_idx];
        if (w_bit_end) begin
          w_tick_nxt = '0;
          if (r_bit_idx == 3'd7)
            w_state_nxt = (PARITY_MODE != PAR_NONE) ? PARITY : STOP;
          else
            w_bit_nxt = r_bit_idx + 1'b1;
        end
      end
      PARITY: begin
        w_tx = (PARITY_MODE == PAR_ODD) ? ~^w_byte : ^w_byte;
        if (w_bit_end) begin
          w_tick_nxt  = '0;
          w_state_nxt = STOP;
        end
      end
      STOP: begin
        if (i_bd_tick && (r_tick_cnt == STOP_END)) begin
          w_tick_nxt = '0;
          if (r_byte_idx == LAST_BYTE) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_byte_nxt  = r_byte_idx + 1'b1;
            w_state_nxt = START;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_tick_cnt  <= '0;
      r_bit_idx   <= '0;
      r_byte_idx  <= '0;
      r_word      <= '0;
      r_word_done <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_tick_cnt  <= w_tick_nxt;
      r_bit_idx   <= w_bit_nxt;
      r_byte_idx  <= w_byte_nxt;
      r_word      <= w_word_nxt;
      r_word_done <= w_done_nxt;
      r_overflow  <= i_wr && w_fifo_full;
    end
  end

  assign o_tx        = w_tx;
  assign o_busy      = (r_state != IDLE);
  assign o_full      = w_fifo_full;
  assign o_empty     = w_fifo_empty;
  assign o_word_done = r_word_done;
  assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_uart_word_tx.sv
// Three parameterisations of uart_word_tx checked against a tick-indexed line model and a word scoreboard.
module tb_uart_word_tx;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic        rst;
  logic        tick;
  bit          tick_rand;
  logic        wr    [3];
  logic [31:0] wdata [3];
  logic        tx    [3];
  logic        full  [3];
  logic        empty [3];
  logic        busy  [3];
  logic        done  [3];
  logic        ovf   [3];
  logic [8:0]  level [3];
  logic [8:0]  lvl0;
  logic [2:0]  lvl1;
  logic [2:0]  lvl2;

  assign level[0] = lvl0;
  assign level[1] = {6'd0, lvl1};
  assign level[2] = {6'd0, lvl2};

  int checks = 0;
  int errors = 0;
  int mon_phase [3];
  int mon_pos   [3];

  typedef struct {
    int          k;
    logic [31:0] w;
  } exp_t;
  exp_t expq[$];

  // inst0: defaults; inst1: 4 bytes, depth 4, even parity, MSB first; inst2: 2 bytes, depth 4, odd parity, 2 stop bits
  uart_word_tx u0 (
    .i_clk(clk), .i_reset(rst), .i_bd_tick(tick), .i_wr(wr[0]), .i_wr_data(wdata[0]),
    .o_tx(tx[0]), .o_full(full[0]), .o_empty(empty[0]), .o_level(lvl0),
    .o_busy(busy[0]), .o_word_done(done[0]), .o_overflow(ovf[0]));

  uart_word_tx #(.WORD_BYTES(4), .FIFO_ADDR_WIDTH(2), .STP_BITS_TICKS(16),
                 .PARITY_MODE(1), .MSB_FIRST(1)) u1 (
    .i_clk(clk), .i_reset(rst), .i_bd_tick(tick), .i_wr(wr[1]), .i_wr_data(wdata[1]),
    .o_tx(tx[1]), .o_full(full[1]), .o_empty(empty[1]), .o_level(lvl1),
    .o_busy(busy[1]), .o_word_done(done[1]), .o_overflow(ovf[1]));

  uart_word_tx #(.WORD_BYTES(2), .FIFO_ADDR_WIDTH(2), .STP_BITS_TICKS(32),
                 .PARITY_MODE(2), .MSB_FIRST(0)) u2 (
    .i_clk(clk), .i_reset(rst), .i_bd_tick(tick), .i_wr(wr[2]), .i_wr_data(wdata[2][15:0]),
    .o_tx(tx[2]), .o_full(full[2]), .o_empty(empty[2]), .o_level(lvl2),
    .o_busy(busy[2]), .o_word_done(done[2]), .o_overflow(ovf[2]));

  function automatic int wb(input int k);
    return (k == 2) ? 2 : 4;
  endfunction
  function automatic int stp(input int k);
    return (k == 2) ? 32 : 16;
  endfunction
  function automatic int par(input int k);
    return k;
  endfunction
  function automatic bit msb(input int k);
    return (k == 1);
  endfunction
  function automatic logic [31:0] wmask(input int k);
    return (k == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction
  function automatic int frame_ticks(input int k);
    return 16 * (9 + ((par(k) != 0) ? 1 : 0)) + stp(k);
  endfunction

  // Expected line level on the pos-th baud tick of a word.
  function automatic logic expbit(input int k, input logic [31:0] w, input int pos);
    int b, r, slot;
    logic [7:0] by;
    b    = pos / frame_ticks(k);
    r    = pos % frame_ticks(k);
    slot = r / 16;
    by   = msb(k) ? w[8*(wb(k)-1-b) +: 8] : w[8*b +: 8];
    if (slot == 0) return 1'b0;
    if (slot <= 8) return by[slot-1];
    if ((par(k) != 0) && (slot == 9)) return (par(k) == 1) ? ^by : ~^by;
    return 1'b1;
  endfunction

  function automatic int pending(input int k);
    int n = 0;
    foreach (expq[i]) if (expq[i].k == k) n++;
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor(input int k);
    logic [31:0] w;
    bit found;
    w = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mon_phase[k] = 0;
        mon_pos[k]   = 0;
      end else begin
        if (mon_phase[k] == 0) begin
          chk($sformatf("idle_done%0d", k), done[k], 0);
          if (tx[k] === 1'b0) begin
            found = 0;
            for (int i = 0; i < expq.size(); i++)
              if (!found && expq[i].k == k) begin
                w = expq[i].w;
                expq.delete(i);
                found = 1;
              end
            chk($sformatf("expected_frame%0d", k), found, 1);
            mon_pos[k]   = 0;
            mon_phase[k] = found ? 1 : 3;
          end
        end else if (mon_phase[k] == 2) begin
          chk($sformatf("word_done%0d", k), done[k], 1);
          chk($sformatf("idle_tx%0d", k), tx[k], 1);
          chk($sformatf("idle_busy%0d", k), busy[k], 0);
          mon_phase[k] = 0;
        end else if (mon_phase[k] == 3) begin
          if (busy[k] === 1'b0) mon_phase[k] = 0;
        end
        if (mon_phase[k] == 1) begin
          chk($sformatf("busy%0d", k), busy[k], 1);
          chk($sformatf("early_done%0d", k), done[k], 0);
          if (tick) begin
            chk($sformatf("tx%0d_w%0h_t%0d", k, w, mon_pos[k]), tx[k], expbit(k, w, mon_pos[k]));
            mon_pos[k]++;
            if (mon_pos[k] == wb(k) * frame_ticks(k)) mon_phase[k] = 2;
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);
  initial monitor(2);

  initial forever begin
    @(posedge clk);
    #1;
    tick = tick_rand ? ($urandom_range(3, 0) != 0) : 1'b1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic push(input int k, input logic [31:0] d, input bit accept);
    logic [31:0] dm;
    dm = d & wmask(k);
    @(posedge clk); #1;
    wr[k]    = 1'b1;
    wdata[k] = dm;
    if (accept) expq.push_back('{k: k, w: dm});
    @(posedge clk); #1;
    wr[k] = 1'b0;
    @(negedge clk);
    chk($sformatf("push_ovf%0d", k), ovf[k], !accept);
  endtask

  task automatic wait_drain(input int k, input int budget);
    int n = 0;
    while ((pending(k) != 0 || mon_phase[k] != 0 || busy[k] !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("drain_pending%0d", k), pending(k), 0);
    chk($sformatf("drain_busy%0d", k), busy[k], 0);
    chk($sformatf("drain_empty%0d", k), empty[k], 1);
  endtask

  initial begin
    int n;
    logic [31:0] w;
    rst = 1'b1;
    tick = 1'b1;
    tick_rand = 0;
    for (int k = 0; k < 3; k++) begin
      wr[k] = 1'b0;
      wdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_tx%0d", k), tx[k], 1);
      chk($sformatf("rst_empty%0d", k), empty[k], 1);
      chk($sformatf("rst_full%0d", k), full[k], 0);
      chk($sformatf("rst_level%0d", k), level[k], 0);
      chk($sformatf("rst_busy%0d", k), busy[k], 0);
      chk($sformatf("rst_done%0d", k), done[k], 0);
      chk($sformatf("rst_ovf%0d", k), ovf[k], 0);
    end

    // Defaults: A1B2C3D4 goes out LSB byte first; start bit falls two cycles after the push
    @(posedge clk); #1;
    wr[0] = 1'b1;
    wdata[0] = 32'hA1B2C3D4;
    expq.push_back('{k: 0, w: 32'hA1B2C3D4});
    @(posedge clk); #1;
    wr[0] = 1'b0;
    @(negedge clk);
    chk("t1_level_after_push", level[0], 1);
    chk("t1_empty_after_push", empty[0], 0);
    chk("t1_tx_still_idle", tx[0], 1);
    @(negedge clk);
    chk("t1_tx_start", tx[0], 0);
    chk("t1_level_after_pop", level[0], 0);
    chk("t1_busy", busy[0], 1);
    push(0, $urandom, 1);
    push(0, $urandom, 1);
    wait_drain(0, 4000);

    // Even parity, MSB-first byte order
    push(1, 32'h0000_0001, 1);
    push(1, $urandom, 1);
    wait_drain(1, 3000);

    // Odd parity, two stop bits, 16-bit words, with irregular baud ticks
    tick_rand = 1;
    push(2, 32'h0000_00FF, 1);
    push(2, $urandom, 1);
    push(2, $urandom, 1);
    wait_drain(2, 4000);
    tick_rand = 0;

    // Overflow: one word in flight, then five back-to-back pushes into a depth-4 FIFO
    push(1, $urandom, 1);
    for (int i = 0; i < 5; i++) begin
      w = $urandom;
      @(posedge clk); #1;
      wr[1] = 1'b1;
      wdata[1] = w;
      if (i < 4) expq.push_back('{k: 1, w: w});
      @(negedge clk);
      chk($sformatf("t4_level_%0d", i), level[1], i);
      chk($sformatf("t4_full_%0d", i), full[1], (i == 4));
      chk($sformatf("t4_ovf_%0d", i), ovf[1], 0);
    end
    @(posedge clk); #1;
    wr[1] = 1'b0;
    @(negedge clk);
    chk("t4_ovf_pulse", ovf[1], 1);
    chk("t4_full_hold", full[1], 1);
    chk("t4_level_hold", level[1], 4);
    @(negedge clk);
    chk("t4_ovf_clear", ovf[1], 0);
    wait_drain(1, 6000);

    // Reset during byte 2 data bits with three words queued
    push(1, $urandom, 1);
    for (int i = 0; i < 3; i++) push(1, $urandom, 1);
    n = 0;
    while (mon_pos[1] < 2 * frame_ticks(1) + 16 + 64 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reached_byte2", (mon_pos[1] >= 2 * frame_ticks(1) + 16 + 64), 1);
    chk("t5_level_before", level[1], 3);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    while (pending(1) != 0) begin
      for (int i = 0; i < expq.size(); i++)
        if (expq[i].k == 1) begin
          expq.delete(i);
          break;
        end
    end
    chk("t5_tx", tx[1], 1);
    chk("t5_level", level[1], 0);
    chk("t5_empty", empty[1], 1);
    chk("t5_busy", busy[1], 0);
    chk("t5_full", full[1], 0);
    repeat (1500) @(negedge clk);
    chk("t5_still_idle", busy[1], 0);
    chk("t5_still_empty", empty[1], 1);

    // Simultaneous push/pop at level 1, then enough words to wrap the pointers
    tick_rand = 1;
    push(1, $urandom, 1);
    push(1, $urandom, 1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done[1] !== 1'b1 && n < 3000);
    chk("t6_done_seen", done[1], 1);
    chk("t6_level_before", level[1], 1);
    w = $urandom;
    wr[1] = 1'b1;
    wdata[1] = w;
    expq.push_back('{k: 1, w: w});
    @(posedge clk); #1;
    wr[1] = 1'b0;
    @(negedge clk);
    chk("t6_level_after", level[1], 1);
    chk("t6_ovf", ovf[1], 0);
    chk("t6_busy", busy[1], 1);
    for (int i = 0; i < 6; i++) begin
      n = 0;
      while (full[1] !== 1'b0 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk($sformatf("t6_not_full_%0d", i), full[1], 0);
      push(1, $urandom, 1);
    end
    wait_drain(1, 12000);
    tick_rand = 0;

    repeat (20) @(negedge clk);
    chk("scoreboard_empty", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_word_tx.md
Name: uart_word_tx

Overview:
Parametrised successor to the debug-unit transmit path: a buffered UART word transmitter with an integrated FIFO. It accepts words of WORD_BYTES bytes from the debug unit. Each word is serialised as WORD_BYTES consecutive UART frames, with configurable byte order, parity and stop length. It sits between debug_unit (o_data_to_fifo / o_write_en_fifo) and the o_tx pin, driven by the shared 16x oversampling baud tick.

Parameters:
WORD_BYTES, 4, bytes per word; word width = 8*WORD_BYTES
FIFO_ADDR_WIDTH, 8, FIFO depth = 2**FIFO_ADDR_WIDTH words
STP_BITS_TICKS, 16, baud ticks the stop bit is held (16 = 1 stop bit, 32 = 2)
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd
MSB_FIRST, 0, 0 = byte [7:0] sent first; 1 = top byte sent first (bits within a byte always LSB first)

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous, active-high reset
i_bd_tick  in  1  16x oversampling baud tick, one-cycle pulse
i_wr  in  1  push request
i_wr_data  in  8*WORD_BYTES  word to push
o_tx  out  1  serial line, idle high
o_full  out  1  FIFO full
o_empty  out  1  FIFO empty
o_level  out  FIFO_ADDR_WIDTH+1  words currently stored
o_busy  out  1  serialiser not in IDLE
o_word_done  out  1  one-cycle pulse after the last stop bit of a word
o_overflow  out  1  one-cycle pulse when a push is dropped

Behaviour:
- Clocking/reset: one clock; reset is synchronous and active-high, on i_clk/i_reset.
- Reset values: o_tx=1, o_empty=1, o_full=0, o_level=0, o_busy=0, o_word_done=0, o_overflow=0.
- Reset mid-frame: FIFO cleared, FSM to IDLE, and o_tx=1 on the cycle after reset is sampled.
- Push:
  - i_wr && !o_full stores the word; o_level increments.
  - i_wr && o_full drops the word and pulses o_overflow the next cycle. The full flag is the registered one; a same-cycle pop does not rescue the push.
- Pop: internal only, by the serialiser in IDLE.
- Simultaneous push and pop: o_level unchanged.
- Pointers wrap modulo 2**FIFO_ADDR_WIDTH. o_full = (level == depth).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: o_tx=1, o_busy=0. If !o_empty: pop the head word into the shift register, byte_idx=0, tick_cnt=0, go to START. Latency from a push into an empty FIFO to o_tx falling: 2 cycles.
  - tick_cnt counts i_bd_tick only. A bit period ends on the tick where tick_cnt==15; tick_cnt then resets to 0.
  - START: o_tx=0 for 16 ticks, then DATA with bit_idx=0.
  - DATA: o_tx = current byte bit[bit_idx], 16 ticks per bit, 8 bits. Then PARITY if PARITY_MODE!=0, else STOP.
  - PARITY: even mode sends ^byte; odd mode sends ~^byte; 16 ticks.
  - STOP: o_tx=1 for STP_BITS_TICKS ticks.
    - If byte_idx < WORD_BYTES-1: byte_idx++ and go to START with no idle gap.
    - Else: pulse o_word_done for 1 cycle and go to IDLE. A queued word starts its START bit 2 cycles later.
- Byte selection:
  - MSB_FIRST=0: byte k = word[8k+7:8k].
  - MSB_FIRST=1: byte k = word[8(WORD_BYTES-1-k)+7 : 8(WORD_BYTES-1-k)].
- The word is captured at pop, so later pushes do not affect a word in flight.
- i_bd_tick while in IDLE is ignored.

Decomposition:
- Shared package uart_pkg holds:
  - serialiser state enum (IDLE, START, DATA, PARITY, STOP)
  - parity constants PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2
  - OVERSAMPLE=16
- One sub-module, word_fifo: a synchronous FIFO parametrised by DATA_WIDTH and ADDR_WIDTH. It provides push/pop, full/empty and level, with reset clearing the pointers.
- The serialiser FSM lives in uart_word_tx.

Test Plan:
1. Defaults, push 32'hA1B2C3D4 with a tick every cycle → four frames, bytes D4, C3, B2, A1, each 0 + 8 LSB-first bits + 1; o_word_done pulses once after 160 ticks × 4; o_level goes 1→0 at the pop.
2. MSB_FIRST=1, PARITY_MODE=1, push 32'h00000001 → bytes 00, 00, 00, 01; parity bits 0, 0, 0, 1; each frame is 11 bit periods.
3. PARITY_MODE=2, STP_BITS_TICKS=32, WORD_BYTES=2, push 16'h00FF → byte FF has parity 1 and byte 00 has parity 1; each stop bit is held 32 ticks.
4. FIFO_ADDR_WIDTH=2: push 5 words back-to-back while the line is busy → o_full after the 4th, o_overflow pulses on the 5th, and exactly 4 words appear on o_tx in push order.
5. Reset asserted mid-DATA of byte 2 with 3 words queued → o_tx=1 next cycle, o_level=0, o_empty=1, o_busy=0, and no further frames are sent.
6. Push and pop in the same cycle at level 1, and pointer wrap after 2**FIFO_ADDR_WIDTH+3 words → o_level stays constant across the push/pop cycle, and the data order is preserved across the wrap.
